psram_qspi_ctrl: RTL and testbench
==================================

// Module: psram_qspi_ctrl
// PURPOSE
//  Bus-side QSPI master for the quad-SPI PSRAM on the SoC peripheral bus.
//  Accepts single 32-bit read/write requests over a valid/ready interface.
//  Sequences CE#/SCK/DIO: quad read EBh with 6 wait cycles, or quad write 38h.
//  Returns one response per request. Sits between the APB/AXI bridge and the pad-level tristate.
// PARAMETERS
//  WAIT_CYCLES  6  dummy SCK cycles between address and read data (EBh)
//  DESEL_CLKS   2  minimum clk cycles CE# held high between transactions
// PORTS
//  clk          in   1   system clock; SCK = clk/2
//  reset        in   1   reset, asynchronous, active-high
//  req_valid    in   1   request valid
//  req_ready    out  1   request accepted when valid&ready
//  req_we       in   1   1=write, 0=read
//  req_addr     in   24  byte address
//  req_wdata    in   32  write data, byte lanes per req_addr[1:0]=0 view
//  req_wstrb    in   4   byte enables (write only)
//  resp_valid   out  1   response valid, held until resp_ready
//  resp_ready   in   1   response accepted
//  resp_rdata   out  32  read data (0 for writes)
//  resp_err     out  1   1 = unsupported wstrb, no bus transaction issued
//  sck          out  1   QSPI clock
//  ce_n         out  1   chip enable, active low
//  dio_o        out  4   data out to pads
//  dio_oe       out  4   per-bit output enable (pad tristate lives outside)
//  dio_i        in   4   data in from pads
// BEHAVIOUR
//  - Reset: ce_n=1, sck=0, dio_oe=0, dio_o=0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
//  - FSM: IDLE->CMD->ADDR->{WAIT->RDATA | WDATA}->DESEL->RESP->IDLE; ERR path is IDLE->RESP.
//  - req_ready=1 only in IDLE; the request is latched on handshake; one outstanding max.
//  - SCK cycle = 2 clk: low phase drives dio_o, high phase (sck=1) is where the device samples on the rising edge.
//  - CMD: 8 SCK, MSB first on dio[0], dio_oe=0001. ADDR: 6 SCK, nibble MSB first, dio_oe=1111.
//  - Read: WAIT 6 SCK with dio_oe=0000; RDATA 8 SCK; sample dio_i at the clk edge ending each high phase.
//    Nibble order: b0[7:4], b0[3:0], b1[7:4] ... b3[3:0]. Total 28 SCK rising edges.
//  - Write: the first set bit of wstrb gives lane L; bus addr = req_addr+L; data sent from byte L upward.
//    Same nibble order as read. N bytes = 2N SCK; total 14+2N rising edges.
//  - Legal wstrb: one bit set (N=1); 0011 or 1100 (N=2); 1111 (N=4). Anything else, incl. 0000 on write:
//    resp_err=1, ce_n stays 1, resp_rdata=0.
//  - End of data: sck held 0; ce_n=1 at the next clk; DESEL holds ce_n=1 for DESEL_CLKS before RESP.
//  - resp_valid/rdata/err stable until resp_ready; RESP->IDLE on handshake; req_ready rises the next clk.
//  - ce_n falls one clk before the first SCK rising edge. sck is never high while ce_n=1.
//  - Async reset mid-transaction aborts immediately: ce_n=1, outputs to reset values, no response.
//  - req_addr[1:0] is passed through unmodified (device is byte-addressed); no alignment check.
// CONFIGURATION
//  PSRAM_CTRL_PERF_EN defined: adds outputs perf_rd_cnt[31:0] and perf_wr_cnt[31:0].
//    Each counts completed (non-err) transactions, increments at DESEL entry, wraps at 2^32, reset to 0.
//  PSRAM_CTRL_PERF_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  psram_ctrl_pkg: state enum, CMD_QREAD=8'hEB, CMD_QWRITE=8'h38, ADDR_NIBBLES=6, DATA_NIBBLES=8.
//  Sub-module psram_wstrb_decode (comb.): wstrb -> {lane L, byte count N, err}; shared with the bench.
//  Top: FSM, SCK phase toggle, SCK-cycle counter, 32-bit shift register for cmd/addr/data.
// TESTING
//  1 Read 0x000100, model word 0xDEADBEEF.
//    -> dio[0] bits 11101011, addr nibbles 0,0,0,1,0,0, 28 SCK, resp_rdata=0xDEADBEEF, resp_err=0.
//  2 Write addr 0x000200, wdata 0x11223344, wstrb 1111 -> cmd 38h, 22 SCK.
//    Data nibbles 4,4,3,3,2,2,1,1; read-back returns 0x11223344.
//  3 Write addr 0x000300, wdata 0xAABBCCDD, wstrb 0100.
//    -> bus addr 0x000302, 16 SCK, nibbles B,B; only byte 0x302 changes.
//  4 wstrb 0101 write, then 0110 write -> resp_err=1 both times; ce_n never low; next read succeeds.
//  5 Hold resp_ready=0 for 10 clk after a read.
//    -> resp_valid and resp_rdata stable, req_ready=0, no new CE# cycle.
//  6 Assert reset at SCK edge 16 of a read -> ce_n=1 same cycle, no resp; post-reset read returns correct data.

Source files
------------

// File: rtl/psram_ctrl_pkg.sv
// Shared types and constants for the quad-SPI PSRAM controller.
package psram_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_WAIT,
      S_RDATA,
      S_WDATA,
      S_DESEL,
      S_RESP
   } state_t;

   localparam logic [7:0] CMD_QREAD    = 8'hEB;
   localparam logic [7:0] CMD_QWRITE   = 8'h38;
   localparam int         ADDR_NIBBLES = 6;
   localparam int         DATA_NIBBLES = 8;

endpackage

// File: rtl/psram_wstrb_decode.sv
// Combinational byte-strobe decoder: first enabled lane, byte count, and
// an error flag for strobe patterns the write sequencer cannot express.
module psram_wstrb_decode (
   input  logic [3:0] wstrb,
   output logic [1:0] lane,
   output logic [2:0] nbytes,
   output logic       err
);

   // Only single bytes, aligned halves and full words map to one burst.
   always_comb begin
      lane   = 2'd0;
      nbytes = 3'd0;
      err    = 1'b0;
      case (wstrb)
         4'b0001: begin lane = 2'd0; nbytes = 3'd1; end
         4'b0010: begin lane = 2'd1; nbytes = 3'd1; end
         4'b0100: begin lane = 2'd2; nbytes = 3'd1; end
         4'b1000: begin lane = 2'd3; nbytes = 3'd1; end
         4'b0011: begin lane = 2'd0; nbytes = 3'd2; end
         4'b1100: begin lane = 2'd2; nbytes = 3'd2; end
         4'b1111: begin lane = 2'd0; nbytes = 3'd4; end
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/psram_qspi_ctrl.sv
// Bus-side QSPI master for the quad PSRAM: one 32-bit read (EBh) or
// write (38h) per request, SCK = clk/2, one response per request.
// Optional feature macro: PSRAM_CTRL_PERF_EN adds perf_rd_cnt/perf_wr_cnt.
module psram_qspi_ctrl #(
   parameter int WAIT_CYCLES = 6,
   parameter int DESEL_CLKS  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [23:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        sck,
   output logic        ce_n,
   output logic [3:0]  dio_o,
   output logic [3:0]  dio_oe,
   input  logic [3:0]  dio_i
`ifdef PSRAM_CTRL_PERF_EN
   ,
   output logic [31:0] perf_rd_cnt,
   output logic [31:0] perf_wr_cnt
`endif
);
   import psram_ctrl_pkg::*;

   state_t      state, state_nx;
   logic        ph, ph_nx;          // 0 = SCK low phase, 1 = SCK high phase
   logic [7:0]  cnt, cnt_nx;        // SCK cycles in shifting states, clks in DESEL
   logic [7:0]  last_idx;
   logic [31:0] sr, sr_nx;          // cmd / addr / data shift register, MSB out first
   logic        we_q;
   logic [23:0] baddr_q;
   logic [31:0] wd_q;
   logic [2:0]  nb_q;
   logic [1:0]  dec_lane;
   logic [2:0]  dec_nbytes;
   logic        dec_err;

   psram_wstrb_decode u_wstrb_decode (
      .wstrb  (req_wstrb),
      .lane   (dec_lane),
      .nbytes (dec_nbytes),
      .err    (dec_err)
   );

   function automatic logic is_shift(input state_t s);
      return s inside {S_CMD, S_ADDR, S_WAIT, S_RDATA, S_WDATA};
   endfunction

   // Wire byte order (b0 first) is the reverse of bus word order.
   function automatic logic [31:0] bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   assign req_ready = (state == S_IDLE);

   // Index of the final SCK cycle of the current shifting state.
   always_comb begin
      last_idx = 8'd0;
      case (state)
         S_CMD:   last_idx = 8'd7;
         S_ADDR:  last_idx = 8'(ADDR_NIBBLES - 1);
         S_WAIT:  last_idx = 8'(WAIT_CYCLES - 1);
         S_RDATA: last_idx = 8'(DATA_NIBBLES - 1);
         S_WDATA: last_idx = {4'b0, nb_q, 1'b0} - 8'd1;
         default: last_idx = 8'd0;
      endcase
   end

   // Next state, SCK phase, cycle counter and shift register; shifting and
   // state changes happen only at the clk edge that ends an SCK high phase.
   always_comb begin
      state_nx = state;
      ph_nx    = 1'b0;
      cnt_nx   = cnt;
      sr_nx    = sr;
      case (state)
         S_IDLE: begin
            cnt_nx = 8'd0;
            if (req_valid) begin
               if (req_we && dec_err) begin
                  state_nx = S_RESP;
               end else begin
                  state_nx = S_CMD;
                  sr_nx    = {(req_we ? CMD_QWRITE : CMD_QREAD), 24'h0};
               end
            end
         end
         S_CMD, S_ADDR, S_WAIT, S_RDATA, S_WDATA: begin
            ph_nx = ~ph;
            if (ph) begin
               cnt_nx = cnt + 8'd1;
               if (state == S_CMD) sr_nx = {sr[30:0], 1'b0};
               else                sr_nx = {sr[27:0], (state == S_RDATA) ? dio_i : 4'h0};
               if (cnt == last_idx) begin
                  cnt_nx = 8'd0;
                  case (state)
                     S_CMD: begin
                        state_nx = S_ADDR;
                        sr_nx    = {baddr_q, 8'h0};
                     end
                     S_ADDR: begin
                        if (we_q) begin
                           state_nx = S_WDATA;
                           sr_nx    = wd_q;
                        end else begin
                           state_nx = S_WAIT;
                        end
                     end
                     S_WAIT:  state_nx = S_RDATA;
                     default: state_nx = S_DESEL;
                  endcase
               end
            end
         end
         S_DESEL: begin
            cnt_nx = cnt + 8'd1;
            if (cnt == 8'(DESEL_CLKS)) begin
               cnt_nx   = 8'd0;
               state_nx = S_RESP;
            end
         end
         S_RESP: if (resp_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Pad drive follows the current state; read phases release the bus.
   always_comb begin
      dio_o  = 4'h0;
      dio_oe = 4'h0;
      case (state)
         S_CMD: begin
            dio_o  = {3'b000, sr[31]};
            dio_oe = 4'b0001;
         end
         S_ADDR, S_WDATA: begin
            dio_o  = sr[31:28];
            dio_oe = 4'b1111;
         end
         default: ;
      endcase
   end

   // Control state and registered pad/response outputs; CE# stays low for
   // the first DESEL clk so the last high phase is followed by a low phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         ph         <= 1'b0;
         cnt        <= 8'd0;
         sck        <= 1'b0;
         ce_n       <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
      end else begin
         state      <= state_nx;
         ph         <= ph_nx;
         cnt        <= cnt_nx;
         sck        <= is_shift(state_nx) & ph_nx;
         ce_n       <= ~(is_shift(state_nx) | (state_nx == S_DESEL && cnt_nx == 8'd0));
         resp_valid <= (state_nx == S_RESP);
         if (state != S_RESP && state_nx == S_RESP) begin
            if (state == S_IDLE) begin
               resp_rdata <= 32'h0;
               resp_err   <= 1'b1;
            end else begin
               resp_rdata <= we_q ? 32'h0 : bswap(sr);
               resp_err   <= 1'b0;
            end
         end
      end
   end

   // Datapath: shift register and request capture on handshake.
   always_ff @(posedge clk) begin
      sr <= sr_nx;
      if (req_valid && req_ready) begin
         we_q    <= req_we;
         baddr_q <= req_addr + (req_we ? {22'b0, dec_lane} : 24'd0);
         wd_q    <= bswap(req_wdata >> {dec_lane, 3'b000});
         nb_q    <= dec_nbytes;
      end
   end

`ifdef PSRAM_CTRL_PERF_EN
   // Completed-transaction counters, bumped on DESEL entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_rd_cnt <= 32'd0;
         perf_wr_cnt <= 32'd0;
      end else if (state != S_DESEL && state_nx == S_DESEL) begin
         if (we_q) perf_wr_cnt <= perf_wr_cnt + 32'd1;
         else      perf_rd_cnt <= perf_rd_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_psram_qspi_ctrl.sv
// Self-checking bench for psram_qspi_ctrl with a behavioural PSRAM model
// and a scoreboard of expected responses.
module tb_psram_qspi_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [23:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic        sck, ce_n;
   logic [3:0]  dio_o, dio_oe, dio_i;

   psram_qspi_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_wstrb  (req_wstrb),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .sck        (sck),
      .ce_n       (ce_n),
      .dio_o      (dio_o),
      .dio_oe     (dio_oe),
      .dio_i      (dio_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          edges;
      logic [23:0] baddr;
      logic [7:0]  cmd;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          failures = 0;
   logic [7:0]  ref_mem [0:4095];
   logic [7:0]  dev_mem [0:4095];
   int          dev_edges = 0;
   int          dev_txn = 0;
   int          oe_bad = 0;
   logic [7:0]  dev_cmd = 8'h00;
   logic [23:0] dev_addr = 24'h0;
   logic [31:0] dev_wrec = 32'h0;
   int          sck_bad = 0;
   int          high_run = 0;
   int          min_high = 1000000;

   function automatic logic [7:0] pat(input int i);
      return 8'(i * 37 + 11);
   endfunction

   // PSRAM model: decodes command/address on SCK rising edges, stores
   // write nibbles and drives read nibbles after each rising edge.
   initial begin : dev
      logic [7:0]  cmd;
      logic [23:0] addr;
      logic [3:0]  hi;
      logic [11:0] ma;
      int          k;
      dio_i = 4'h0;
      hi    = 4'h0;
      for (int i = 0; i < 4096; i++) dev_mem[i] = pat(i);
      dev_mem[12'h100] = 8'hEF; dev_mem[12'h101] = 8'hBE;
      dev_mem[12'h102] = 8'hAD; dev_mem[12'h103] = 8'hDE;
      forever begin
         @(negedge ce_n);
         dev_edges = 0; cmd = 8'h00; addr = 24'h0; dev_wrec = 32'h0;
         while (ce_n === 1'b0) begin
            @(posedge sck or posedge ce_n);
            #1;
            if (ce_n !== 1'b0) break;
            if (dev_edges < 8) begin
               cmd = {cmd[6:0], dio_o[0]};
               if (dio_oe !== 4'b0001) oe_bad++;
            end else if (dev_edges < 14) begin
               addr = {addr[19:0], dio_o};
               if (dio_oe !== 4'b1111) oe_bad++;
            end else if (cmd == 8'h38) begin
               k = dev_edges - 14;
               if (dio_oe !== 4'b1111) oe_bad++;
               dev_wrec = {dev_wrec[27:0], dio_o};
               if (k % 2 == 0) hi = dio_o;
               else begin
                  ma = addr[11:0] + 12'(k / 2);
                  dev_mem[ma] = {hi, dio_o};
               end
            end else begin
               if (dio_oe !== 4'b0000) oe_bad++;
               if (dev_edges >= 20 && dev_edges < 28) begin
                  k  = dev_edges - 20;
                  ma = addr[11:0] + 12'(k / 2);
                  dio_i = (k % 2 == 0) ? dev_mem[ma][7:4] : dev_mem[ma][3:0];
               end
            end
            dev_edges++;
         end
         dev_cmd  = cmd;
         dev_addr = addr;
         dev_txn++;
      end
   end

   // Bus-level protocol monitor: SCK never high while deselected, and
   // minimum CE# high time between selections.
   initial begin : mon
      forever begin
         @(negedge clk);
         if (sck === 1'b1 && ce_n === 1'b1) sck_bad++;
         if (ce_n === 1'b1) high_run++;
         else if (ce_n === 1'b0) begin
            if (high_run > 0 && high_run < min_high) min_high = high_run;
            high_run = 0;
         end
      end
   end

   // Push the reference expectation, then perform the request handshake.
   task automatic send(input logic we, input logic [23:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, output logic ok);
      exp_t e;
      int   lane, nb, n;
      lane = 0; nb = 0; n = 0;
      e.cmd = we ? 8'h38 : 8'hEB; e.err = 1'b0; e.rdata = 32'h0; e.baddr = a; e.edges = 28;
      if (!we) begin
         for (int i = 0; i < 4; i++) e.rdata[8*i +: 8] = ref_mem[a[11:0] + 12'(i)];
      end else begin
         case (ws)
            4'b0001: begin lane = 0; nb = 1; end
            4'b0010: begin lane = 1; nb = 1; end
            4'b0100: begin lane = 2; nb = 1; end
            4'b1000: begin lane = 3; nb = 1; end
            4'b0011: begin lane = 0; nb = 2; end
            4'b1100: begin lane = 2; nb = 2; end
            4'b1111: begin lane = 0; nb = 4; end
            default: begin lane = 0; nb = 0; end
         endcase
         if (nb == 0) begin
            e.err = 1'b1; e.edges = 0;
         end else begin
            e.baddr = a + 24'(lane);
            e.edges = 14 + 2 * nb;
            for (int i = 0; i < nb; i++) ref_mem[a[11:0] + 12'(lane + i)] = wd[8*(lane+i) +: 8];
         end
      end
      sbq.push_back(e);
      ok = 1'b1;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_wstrb = ws;
      while (req_ready !== 1'b1) begin
         if (n >= 2000) begin ok = 1'b0; break; end
         @(negedge clk); n++;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_resp(output logic ok, output logic [31:0] rd, output logic er);
      int n;
      n = 0; ok = 1'b1;
      @(negedge clk);
      while (resp_valid !== 1'b1) begin
         if (n >= 3000) begin ok = 1'b0; break; end
         @(negedge clk); n++;
      end
      rd = resp_rdata; er = resp_err;
   endtask

   task automatic ack_resp;
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
   endtask

   // Full transaction: send, collect the response, pop its expectation.
   task automatic do_txn(input logic we, input logic [23:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input logic ack, output logic ok,
                         output logic [31:0] rd, output logic er, output exp_t e);
      logic ok1, ok2;
      send(we, a, wd, ws, ok1);
      wait_resp(ok2, rd, er);
      e  = sbq.pop_front();
      ok = ok1 & ok2;
      if (ack && ok) ack_resp;
   endtask

   task automatic test_reset;
      checks++;
      if (ce_n !== 1'b1 || sck !== 1'b0 || dio_oe !== 4'h0 || dio_o !== 4'h0 ||
          req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got ce_n=%b sck=%b oe=%h o=%h rdy=%b rv=%b rd=%h err=%b exp 1 0 0 0 1 0 0 0",
                  ce_n, sck, dio_oe, dio_o, req_ready, resp_valid, resp_rdata, resp_err);
      end
   endtask

   task automatic test_read_basic;
      logic ok, er; logic [31:0] rd; exp_t e;
      do_txn(1'b0, 24'h000100, 32'h0, 4'h0, 1'b1, ok, rd, er, e);
      checks++;
      if (!ok) begin failures++; $display("FAIL read1_timeout got=timeout exp=response"); return; end
      checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL read1_rdata got=%h exp=deadbeef", rd); end
      checks++; if (er !== 1'b0) begin failures++; $display("FAIL read1_err got=%b exp=0", er); end
      checks++; if (dev_cmd !== 8'hEB) begin failures++; $display("FAIL read1_cmd got=%h exp=eb", dev_cmd); end
      checks++; if (dev_addr !== 24'h000100) begin failures++; $display("FAIL read1_addr got=%h exp=000100", dev_addr); end
      checks++; if (dev_edges != e.edges) begin failures++; $display("FAIL read1_sck got=%0d exp=%0d", dev_edges, e.edges); end
   endtask

   task automatic test_write_word;
      logic ok, er; logic [31:0] rd; exp_t e;
      do_txn(1'b1, 24'h000200, 32'h11223344, 4'b1111, 1'b1, ok, rd, er, e);
      checks++;
      if (!ok) begin failures++; $display("FAIL wr4_timeout got=timeout exp=response"); return; end
      checks++; if (dev_cmd !== 8'h38) begin failures++; $display("FAIL wr4_cmd got=%h exp=38", dev_cmd); end
      checks++; if (dev_edges != 22) begin failures++; $display("FAIL wr4_sck got=%0d exp=22", dev_edges); end
      checks++; if (dev_wrec !== 32'h44332211) begin failures++; $display("FAIL wr4_nibbles got=%h exp=44332211", dev_wrec); end
      checks++; if (rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL wr4_resp got=%h/%b exp=0/0", rd, er); end
      do_txn(1'b0, 24'h000200, 32'h0, 4'h0, 1'b1, ok, rd, er, e);
      checks++; if (!ok || rd !== 32'h11223344) begin failures++; $display("FAIL wr4_readback got=%h exp=11223344", rd); end
   endtask

   task automatic test_write_byte;
      logic ok, er; logic [31:0] rd; exp_t e;
      do_txn(1'b1, 24'h000300, 32'hAABBCCDD, 4'b0100, 1'b1, ok, rd, er, e);
      checks++;
      if (!ok) begin failures++; $display("FAIL wr1_timeout got=timeout exp=response"); return; end
      checks++; if (dev_addr !== 24'h000302) begin failures++; $display("FAIL wr1_addr got=%h exp=000302", dev_addr); end
      checks++; if (dev_edges != 16) begin failures++; $display("FAIL wr1_sck got=%0d exp=16", dev_edges); end
      checks++; if (dev_wrec !== 32'h000000BB) begin failures++; $display("FAIL wr1_nibbles got=%h exp=000000bb", dev_wrec); end
      checks++;
      if (dev_mem[12'h300] !== pat(12'h300) || dev_mem[12'h301] !== pat(12'h301) ||
          dev_mem[12'h302] !== 8'hBB || dev_mem[12'h303] !== pat(12'h303)) begin
         failures++;
         $display("FAIL wr1_bytes got=%h%h%h%h exp=%h%h%h%h", dev_mem[12'h303], dev_mem[12'h302],
                  dev_mem[12'h301], dev_mem[12'h300], pat(12'h303), 8'hBB, pat(12'h301), pat(12'h300));
      end
   endtask

   task automatic test_bad_wstrb;
      logic ok, er; logic [31:0] rd; exp_t e; int txn0;
      logic [3:0] bad [2];
      bad[0] = 4'b0101; bad[1] = 4'b0110;
      txn0 = dev_txn;
      for (int i = 0; i < 2; i++) begin
         do_txn(1'b1, 24'h000500, 32'hCAFEF00D, bad[i], 1'b1, ok, rd, er, e);
         checks++;
         if (!ok || er !== e.err || rd !== 32'h0) begin
            failures++; $display("FAIL bad_wstrb_%0d got=%h/%b exp=00000000/%b", i, rd, er, e.err);
         end
      end
      checks++; if (dev_txn != txn0) begin failures++; $display("FAIL bad_wstrb_ce got=%0d exp=%0d", dev_txn, txn0); end
      do_txn(1'b0, 24'h000500, 32'h0, 4'h0, 1'b1, ok, rd, er, e);
      checks++; if (!ok || rd !== e.rdata || er !== 1'b0) begin failures++; $display("FAIL bad_wstrb_next got=%h/%b exp=%h/0", rd, er, e.rdata); end
   endtask

   task automatic test_resp_hold;
      logic ok, er; logic [31:0] rd; exp_t e; int txn0;
      do_txn(1'b0, 24'h000200, 32'h0, 4'h0, 1'b0, ok, rd, er, e);
      checks++;
      if (!ok) begin failures++; $display("FAIL hold_timeout got=timeout exp=response"); return; end
      txn0 = dev_txn;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || req_ready !== 1'b0 || ce_n !== 1'b1) begin
            failures++;
            $display("FAIL hold_cycle%0d got rv=%b rd=%h rdy=%b ce_n=%b exp 1 %h 0 1", c, resp_valid, resp_rdata, req_ready, ce_n, e.rdata);
         end
      end
      checks++; if (dev_txn != txn0) begin failures++; $display("FAIL hold_no_ce got=%0d exp=%0d", dev_txn, txn0); end
      ack_resp;
   endtask

   task automatic test_reset_abort;
      logic ok, er; logic [31:0] rd; exp_t e; int n, rv_seen;
      send(1'b0, 24'h000100, 32'h0, 4'h0, ok);
      n = 0;
      while (dev_edges < 16 || ce_n !== 1'b0) begin
         if (n >= 500) begin ok = 1'b0; break; end
         @(negedge clk); n++;
      end
      e = sbq.pop_front();
      checks++;
      if (!ok) begin failures++; $display("FAIL abort_reach got=timeout exp=edge16"); end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (ce_n !== 1'b1 || sck !== 1'b0 || dio_oe !== 4'h0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL abort_outputs got ce_n=%b sck=%b oe=%h rv=%b rdy=%b exp 1 0 0 0 1", ce_n, sck, dio_oe, resp_valid, req_ready);
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      rv_seen = 0;
      repeat (30) begin @(negedge clk); if (resp_valid === 1'b1) rv_seen++; end
      checks++; if (rv_seen != 0) begin failures++; $display("FAIL abort_no_resp got=%0d exp=0", rv_seen); end
      do_txn(1'b0, 24'h000100, 32'h0, 4'h0, 1'b1, ok, rd, er, e);
      checks++; if (!ok || rd !== 32'hDEADBEEF || er !== 1'b0) begin failures++; $display("FAIL abort_reread got=%h/%b exp=deadbeef/0", rd, er); end
   endtask

   task automatic test_back_to_back;
      logic ok, er, we; logic [31:0] rd, wd; logic [23:0] a; exp_t e; int bad;
      logic [3:0] legal [7];
      legal[0] = 4'b0001; legal[1] = 4'b0010; legal[2] = 4'b0100; legal[3] = 4'b1000;
      legal[4] = 4'b0011; legal[5] = 4'b1100; legal[6] = 4'b1111;
      for (int i = 0; i < 12; i++) begin
         we = ($urandom_range(0, 1) == 1);
         a  = 24'h000400 + 24'($urandom_range(0, 1000));
         wd = $urandom;
         do_txn(we, a, wd, legal[$urandom_range(0, 6)], 1'b1, ok, rd, er, e);
         checks++;
         if (!ok || rd !== e.rdata || er !== e.err || dev_edges != e.edges || dev_addr !== e.baddr || dev_cmd !== e.cmd) begin
            failures++;
            $display("FAIL b2b_%0d got rd=%h err=%b sck=%0d addr=%h cmd=%h exp %h %b %0d %h %h",
                     i, rd, er, dev_edges, dev_addr, dev_cmd, e.rdata, e.err, e.edges, e.baddr, e.cmd);
         end
      end
      bad = 0;
      for (int i = 0; i < 4096; i++) if (dev_mem[i] !== ref_mem[i]) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL mem_image got=%0d_diff exp=0_diff", bad); end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
      ref_mem[12'h100] = 8'hEF; ref_mem[12'h101] = 8'hBE;
      ref_mem[12'h102] = 8'hAD; ref_mem[12'h103] = 8'hDE;
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 24'h0;
      req_wdata = 32'h0; req_wstrb = 4'h0; resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      test_reset;
      reset = 1'b0;
      @(negedge clk);
      test_read_basic;
      test_write_word;
      test_write_byte;
      test_bad_wstrb;
      test_resp_hold;
      test_reset_abort;
      test_back_to_back;
      repeat (5) @(negedge clk);
      checks++; if (sck_bad != 0) begin failures++; $display("FAIL sck_while_deselected got=%0d exp=0", sck_bad); end
      checks++; if (oe_bad != 0) begin failures++; $display("FAIL dio_oe_phase got=%0d exp=0", oe_bad); end
      checks++; if (min_high < 2) begin failures++; $display("FAIL ce_high_min got=%0d exp>=2", min_high); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
